datapath_gen: RTL
=================

// Module: datapath_gen
// PURPOSE
//  Parametrised LC-3-class datapath: PC, IR, MAR, MDR, NZP/BEN, register file, ALU, address adder, one-gate bus.
//  Adds an internal memory-access sequencer (req/ready handshake, timeout) and bus-conflict detection.
//  Sits between the control FSM (drives LD_*/Gate*/mux selects, mem_start) and the SRAM/IO wrapper.
// PARAMETERS
//  DATA_W       16      datapath width; >=16; IR fields use bits [15:0], immediates sign-extend to DATA_W
//  REG_ADDR_W   3       register-file address width; 2**REG_ADDR_W registers; IR selects use low bits, zero-extended
//  MEM_TIMEOUT  15      max cycles waiting for mem_rdy before abort; 1..255
//  PC_RST       0       PC value after reset
// PORTS
//  Clk          in   1       clock, rising edge
//  Reset        in   1       asynchronous, active-low reset
//  LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED  in 1 each  register load enables
//  GatePC, GateMDR, GateALU, GateMARMUX  in 1 each  bus drive enables
//  PCMUX, ADDR2MUX, ALUK  in  2 each  0:PC+1/BUS/adder; 0:off6/off9/off11/zero; ADD/AND/NOT/PASSA
//  DRMUX, SR1MUX, SR2MUX, ADDR1MUX  in 1 each  DR=IR[11:9]|R7; SR1=IR[11:9]|IR[8:6]; SR2=reg|imm5; PC|SR1
//  mem_start    in   1       pulse: begin access at MAR
//  mem_wr       in   1       sampled with mem_start: 1=write MDR, 0=read
//  mem_rdy      in   1       memory completes this cycle
//  MDR_In       in   DATA_W  read data from memory
//  mem_ce, mem_we  out 1 each  access strobe, write qualifier
//  mem_busy     out  1       sequencer not IDLE
//  mem_done     out  1       1-cycle pulse on successful completion
//  mem_err      out  1       1-cycle pulse on timeout
//  bus_conflict out  1       sticky: >1 gate asserted in any cycle
//  BEN          out  1       branch enable
//  LED          out  12      pause display
//  IR, MDR, MAR, PC  out DATA_W  register values
// BEHAVIOUR
//  Reset: PC=PC_RST; IR/MAR/MDR/regs/LED=0; NZP=3'b010; BEN=0; FSM IDLE; all strobes/flags 0.
//  Bus (comb): priority PC>MDR>MARMUX>ALU; no gate -> 0; two or more gates -> bus_conflict set next edge, held until reset.
//  Registers load on the rising edge when LD_x=1; else hold. LD_REG writes BUS to DR; R0 not hardwired.
//  Adder: ADDR1 + ADDR2, modulo 2**DATA_W; PC+1 wraps max->0. ALU modulo 2**DATA_W, no carry.
//  NZP on LD_CC from BUS: N=BUS[DATA_W-1]; Z=(BUS==0); P=otherwise; exactly one set.
//  BEN on LD_BEN: |(IR[11:9] & NZP) using current NZP (same-edge LD_CC not yet visible).
//  LED on LD_LED <= IR[11:0]; otherwise holds last value.
//  Sequencer FSM: IDLE -mem_start-> ACCESS; ACCESS: mem_ce=1, mem_we=latched wr, wait counter increments.
//   ACCESS & mem_rdy: read -> MDR<=MDR_In; go DONE. DONE: mem_done=1 one cycle -> IDLE.
//   ACCESS & counter==MEM_TIMEOUT & !mem_rdy: mem_err=1 one cycle, MDR unchanged -> IDLE.
//   mem_rdy and timeout same cycle: completion wins. mem_rdy outside ACCESS: ignored.
//   mem_start while busy: ignored, no queueing. Earliest restart: cycle after DONE.
//   Read completion vs LD_MDR same edge: memory data wins. LD_MAR while busy: MAR loads; access address unaffected (latched at start).
//  Latency: zero-wait read: start@t, ce@t+1, rdy@t+1, MDR/mem_done valid @t+2.
//  Reset mid-access: immediate IDLE, ce/we low, no done/err pulse.
// TESTING
//  1 GatePC only, PC=0x3000, LD_MAR, then mem_start rd, mem_rdy after 2 cycles, MDR_In=0x1234 -> MDR=0x1234, one mem_done, ce high 3 cycles.
//  2 mem_start rd, mem_rdy never -> mem_err pulse at wait count 15, MDR unchanged, mem_busy low next cycle.
//  3 ADD R1,R2,#-1 with R2=0 -> R1=0xFFFF, LD_CC -> NZP=100; BRn (IR[11:9]=100) LD_BEN -> BEN=1.
//  4 GatePC & GateALU same cycle -> BUS=PC, bus_conflict=1 and stays 1 until Reset low.
//  5 PC=0xFFFF, PCMUX=0, LD_PC -> PC=0x0000; LD_LED with IR=0x0ABC -> LED=0xABC held after LD_LED drops.
//  6 Reset low mid-ACCESS -> mem_ce=0 asynchronously, PC=PC_RST, NZP=010, no mem_done/mem_err.

Source files
------------

// File: rtl/datapath_gen.sv
// datapath_gen: LC-3-class datapath (bus, registers, ALU, address adder) with a
// timed memory-access sequencer and sticky bus-conflict detection.
module datapath_gen #(
  parameter int DATA_W = 16,
  parameter int REG_ADDR_W = 3,
  parameter int MEM_TIMEOUT = 15,
  parameter logic [DATA_W-1:0] PC_RST = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_mar,
  input  logic              ld_mdr,
  input  logic              ld_ir,
  input  logic              ld_ben,
  input  logic              ld_cc,
  input  logic              ld_reg,
  input  logic              ld_pc,
  input  logic              ld_led,
  input  logic              gate_pc,
  input  logic              gate_mdr,
  input  logic              gate_alu,
  input  logic              gate_marmux,
  input  logic [1:0]        pcmux,
  input  logic [1:0]        addr2mux,
  input  logic [1:0]        aluk,
  input  logic              drmux,
  input  logic              sr1mux,
  input  logic              sr2mux,
  input  logic              addr1mux,
  input  logic              mem_start,
  input  logic              mem_wr,
  input  logic              mem_rdy,
  input  logic [DATA_W-1:0] mdr_in,
  output logic              mem_ce,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic              mem_busy,
  output logic              mem_done,
  output logic              mem_err,
  output logic              bus_conflict,
  output logic              ben,
  output logic [11:0]       led,
  output logic [DATA_W-1:0] ir,
  output logic [DATA_W-1:0] mdr,
  output logic [DATA_W-1:0] mar,
  output logic [DATA_W-1:0] pc
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t state;
  logic [7:0] cnt;
  logic [2:0] nzp;
  logic [2:0] n_gates;
  logic [DATA_W-1:0] regs [2**REG_ADDR_W];
  logic [DATA_W-1:0] bus, sr1, sr2, alu, addr1, addr2, adder, pc_next;
  logic [REG_ADDR_W-1:0] dr, sr1_a;
  assign dr = drmux ? REG_ADDR_W'(7) : REG_ADDR_W'(ir[11:9]);
  assign sr1_a = sr1mux ? REG_ADDR_W'(ir[8:6]) : REG_ADDR_W'(ir[11:9]);
  assign sr1 = regs[sr1_a];
  assign sr2 = sr2mux ? DATA_W'($signed(ir[4:0])) : regs[REG_ADDR_W'(ir[2:0])];
  assign alu = aluk == 2'd0 ? sr1 + sr2 : aluk == 2'd1 ? sr1 & sr2 : aluk == 2'd2 ? ~sr1 : sr1;
  assign addr1 = addr1mux ? sr1 : pc;
  assign addr2 = addr2mux == 2'd0 ? DATA_W'($signed(ir[5:0])) :
                 addr2mux == 2'd1 ? DATA_W'($signed(ir[8:0])) :
                 addr2mux == 2'd2 ? DATA_W'($signed(ir[10:0])) : '0;
  assign adder = addr1 + addr2;
  assign pc_next = pcmux == 2'd0 ? pc + DATA_W'(1) : pcmux == 2'd1 ? bus : adder;
  // Fixed gate priority keeps the bus defined even when the controller misbehaves
  assign bus = gate_pc ? pc : gate_mdr ? mdr : gate_marmux ? adder : gate_alu ? alu : '0;
  assign n_gates = 3'(gate_pc) + 3'(gate_mdr) + 3'(gate_alu) + 3'(gate_marmux);
  assign mem_busy = state != IDLE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pc <= PC_RST;
      ir <= '0;
      mar <= '0;
      led <= '0;
      nzp <= 3'b010;
      ben <= 1'b0;
      bus_conflict <= 1'b0;
    end else begin
      if (ld_pc) pc <= pc_next;
      if (ld_ir) ir <= bus;
      if (ld_mar) mar <= bus;
      if (ld_led) led <= ir[11:0];
      if (ld_cc) nzp <= bus[DATA_W-1] ? 3'b100 : bus == '0 ? 3'b010 : 3'b001;
      if (ld_ben) ben <= |(ir[11:9] & nzp);
      if (n_gates > 3'd1) bus_conflict <= 1'b1;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < 2**REG_ADDR_W; i++) regs[i] <= '0;
    end else if (ld_reg) begin
      regs[dr] <= bus;
    end
  // Address and direction are captured at start so later MAR loads cannot disturb the access
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      mem_ce <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_done <= 1'b0;
      mem_err <= 1'b0;
      mdr <= '0;
    end else begin
      mem_done <= 1'b0;
      mem_err <= 1'b0;
      if (state == ACCESS && mem_rdy && !mem_we) mdr <= mdr_in;
      else if (ld_mdr) mdr <= bus;
      case (state)
        IDLE:
          if (mem_start) begin
            state <= ACCESS;
            cnt <= 8'd1;
            mem_ce <= 1'b1;
            mem_we <= mem_wr;
            mem_addr <= mar;
          end
        ACCESS:
          if (mem_rdy) begin
            state <= DONE;
            mem_ce <= 1'b0;
            mem_we <= 1'b0;
            mem_done <= 1'b1;
          end else if (cnt == 8'(MEM_TIMEOUT)) begin
            state <= IDLE;
            mem_ce <= 1'b0;
            mem_we <= 1'b0;
            mem_err <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        default: state <= IDLE;
      endcase
    end
endmodule
